// File: rtl/lzx_cnt_pkg.sv
// Shared constants for the lzx up/down counter family.
// Mode constants select the counter's end-of-range behaviour.
// Direction constants give the meaning of the U_D input.
package lzx_cnt_pkg;

    localparam bit LZX_CNT_WRAP = 1'b0;
    localparam bit LZX_CNT_SAT  = 1'b1;

    localparam bit LZX_DIR_UP = 1'b1;
    localparam bit LZX_DIR_DN = 1'b0;

endpackage

// File: rtl/lzx_cnt_step.sv
// Next-count computation for the lzx up/down counter.
// This block is purely combinational and works over the range 0..max.
//   q      : current count
//   max    : terminal value (top of range)
//   u_d    : direction, 1 = up, 0 = down
//   sat    : end-of-range mode, 0 = wrap, 1 = saturate
//   q_next : value to load if a count is taken
//   at_end : q sits on the range end for the current direction
module lzx_cnt_step
    import lzx_cnt_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] max,
    input  logic             u_d,
    input  logic             sat,
    output logic [WIDTH-1:0] q_next,
    output logic             at_end
);

    always_comb begin
        q_next = q;
        at_end = 1'b0;
        if (u_d == LZX_DIR_UP) begin
            at_end = (q == max);
            if (q < max) begin
                q_next = q + 1'b1;
            end else if (sat == LZX_CNT_SAT) begin
                // Saturation also pulls an out-of-range count (from a load) back to max.
                q_next = max;
            end else begin
                q_next = '0;
            end
        end else begin
            at_end = (q == '0);
            if (q != '0) begin
                // Decrement applies even above max; no clamp in this direction.
                q_next = q - 1'b1;
            end else if (sat == LZX_CNT_SAT) begin
                q_next = '0;
            end else begin
                q_next = max;
            end
        end
    end

endmodule

// File: rtl/lzx_updn_cnt.sv
// Presettable, cascadable up/down counter with a programmable terminal value.
// The count range is 0..MAX. The end-of-range mode is fixed by the SAT parameter.
//   CP    : clock (rising edge)
//   MR    : synchronous master reset, active-high
//   PE_n  : parallel load enable, active-low
//   CEP_n : count enable parallel, active-low
//   CET_n : count enable trickle, active-low; also gates TC
//   U_D   : direction, 1 = up, 0 = down
//   D     : parallel load data, loaded unmodified
//   MAX   : terminal value
//   Q     : registered count
//   TC    : combinational terminal count, for chaining into the next stage's CET_n
//   WRAP  : registered one-cycle pulse after a count taken at the range end
module lzx_updn_cnt
    import lzx_cnt_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter bit SAT   = LZX_CNT_WRAP
) (
    input  logic             CP,
    input  logic             MR,
    input  logic             PE_n,
    input  logic             CEP_n,
    input  logic             CET_n,
    input  logic             U_D,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] MAX,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             WRAP
);

    logic [WIDTH-1:0] q_next;
    logic             at_end;
    logic             count;

    lzx_cnt_step #(.WIDTH(WIDTH)) u_step (
        .q      (Q),
        .max    (MAX),
        .u_d    (U_D),
        .sat    (SAT),
        .q_next (q_next),
        .at_end (at_end)
    );

    assign count = !CEP_n && !CET_n;
    assign TC    = !CET_n && at_end;

    // Priority: reset, then load, then count, then hold.
    // WRAP equals TC on a count edge, because CET_n is low whenever a count is taken.
    always_ff @(posedge CP) begin
        if (MR) begin
            Q    <= '0;
            WRAP <= 1'b0;
        end else if (!PE_n) begin
            Q    <= D;
            WRAP <= 1'b0;
        end else if (count) begin
            Q    <= q_next;
            WRAP <= at_end;
        end else begin
            WRAP <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lzx_updn_cnt.sv
// Self-checking bench for lzx_updn_cnt.
// Two 8-bit instances share one set of stimulus: one wraps, the other saturates.
// A pair of 4-bit instances forms a cascade.
// A behavioural model tracks both 8-bit instances.
module tb_lzx_updn_cnt;

    logic       clk = 1'b0;
    logic       mr, pe_n, cep_n, cet_n, ud;
    logic [7:0] d, mx;
    logic [7:0] q0, q1;
    logic       tc0, tc1, w0, w1;

    logic       c_mr, c_cep_n;
    logic       c_pe_n   = 1'b1;
    logic       c_ud     = 1'b1;
    logic       c_cet_lo = 1'b0;
    logic [3:0] c_d      = 4'd0;
    logic [3:0] c_max    = 4'hF;
    logic [3:0] q_lo, q_hi;
    logic       tc_lo, tc_hi, w_lo, w_hi, c_cet_hi;

    int n_checks = 0;
    int n_fail   = 0;
    int mq0, mq1;
    bit mw0, mw1;

    always #5 clk = ~clk;

    assign c_cet_hi = ~tc_lo;

    lzx_updn_cnt #(.WIDTH(8), .SAT(1'b0)) dut_wrap (
        .CP(clk), .MR(mr), .PE_n(pe_n), .CEP_n(cep_n), .CET_n(cet_n), .U_D(ud),
        .D(d), .MAX(mx), .Q(q0), .TC(tc0), .WRAP(w0));

    lzx_updn_cnt #(.WIDTH(8), .SAT(1'b1)) dut_sat (
        .CP(clk), .MR(mr), .PE_n(pe_n), .CEP_n(cep_n), .CET_n(cet_n), .U_D(ud),
        .D(d), .MAX(mx), .Q(q1), .TC(tc1), .WRAP(w1));

    lzx_updn_cnt #(.WIDTH(4), .SAT(1'b0)) dut_lo (
        .CP(clk), .MR(c_mr), .PE_n(c_pe_n), .CEP_n(c_cep_n), .CET_n(c_cet_lo), .U_D(c_ud),
        .D(c_d), .MAX(c_max), .Q(q_lo), .TC(tc_lo), .WRAP(w_lo));

    lzx_updn_cnt #(.WIDTH(4), .SAT(1'b0)) dut_hi (
        .CP(clk), .MR(c_mr), .PE_n(c_pe_n), .CEP_n(c_cep_n), .CET_n(c_cet_hi), .U_D(c_ud),
        .D(c_d), .MAX(c_max), .Q(q_hi), .TC(tc_hi), .WRAP(w_hi));

    // Range rules stated as plain integer arithmetic over 0..max.
    function automatic int ref_next(int q, int m, bit up, bit sat);
        if (up) begin
            if (q < m) return q + 1;
            return sat ? m : 0;
        end
        if (q > 0) return q - 1;
        return sat ? 0 : m;
    endfunction

    function automatic bit ref_tc(int q, int m, bit up, bit cetn);
        return !cetn && (up ? (q == m) : (q == 0));
    endfunction

    // Advance the model from the inputs present at the edge, then step past the edge.
    task automatic tick();
        int n0, n1;
        bit e0, e1;
        n0 = mq0; n1 = mq1; e0 = 1'b0; e1 = 1'b0;
        if (mr) begin
            n0 = 0; n1 = 0;
        end else if (!pe_n) begin
            n0 = int'(d); n1 = int'(d);
        end else if (!cep_n && !cet_n) begin
            e0 = ref_tc(mq0, int'(mx), ud, 1'b0);
            e1 = ref_tc(mq1, int'(mx), ud, 1'b0);
            n0 = ref_next(mq0, int'(mx), ud, 1'b0);
            n1 = ref_next(mq1, int'(mx), ud, 1'b1);
        end
        @(posedge clk);
        #1;
        mq0 = n0; mq1 = n1; mw0 = e0; mw1 = e1;
    endtask

    task automatic test_reset();
        mr = 1'b1; pe_n = 1'b0; d = 8'd7; cep_n = 1'b0; cet_n = 1'b0; ud = 1'b0; mx = 8'd9;
        c_mr = 1'b1; c_cep_n = 1'b1;
        tick();
        n_checks++; if (q0 !== 8'd0 || w0 !== 1'b0) begin n_fail++;
            $display("FAIL reset_wrap: got q=%0d wrap=%b, want q=0 wrap=0", q0, w0); end
        n_checks++; if (q1 !== 8'd0 || w1 !== 1'b0) begin n_fail++;
            $display("FAIL reset_sat: got q=%0d wrap=%b, want q=0 wrap=0", q1, w1); end
        n_checks++; if (tc0 !== 1'b1) begin n_fail++;
            $display("FAIL reset_tc_down: got %b want 1", tc0); end
        ud = 1'b1; #1;
        n_checks++; if (tc0 !== 1'b0) begin n_fail++;
            $display("FAIL reset_tc_up: got %b want 0", tc0); end
        mr = 1'b0; pe_n = 1'b1; cep_n = 1'b1; c_mr = 1'b0;
        tick();
    endtask

    task automatic test_up_wrap();
        int exp_q[12];
        exp_q = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        mx = 8'd9; ud = 1'b1; cep_n = 1'b0; cet_n = 1'b0; pe_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++; if (q0 !== 8'(exp_q[i])) begin n_fail++;
                $display("FAIL up_wrap_q edge %0d: got %0d want %0d", i, q0, exp_q[i]); end
            n_checks++; if (tc0 !== (exp_q[i] == 9)) begin n_fail++;
                $display("FAIL up_wrap_tc edge %0d: got %b want %b", i, tc0, exp_q[i] == 9); end
            n_checks++; if (w0 !== (i == 9)) begin n_fail++;
                $display("FAIL up_wrap_wrap edge %0d: got %b want %b", i, w0, i == 9); end
            n_checks++; if (q1 !== 8'(mq1) || w1 !== mw1) begin n_fail++;
                $display("FAIL up_wrap_satdut edge %0d: got q=%0d w=%b want q=%0d w=%b", i, q1, w1, mq1, mw1); end
        end
    endtask

    task automatic test_down_wrap();
        int exp_q[4];
        exp_q = '{1, 0, 9, 8};
        mx = 8'd9; pe_n = 1'b0; d = 8'd2;
        tick();
        pe_n = 1'b1; ud = 1'b0; cep_n = 1'b0; cet_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (q0 !== 8'(exp_q[i])) begin n_fail++;
                $display("FAIL down_wrap_q edge %0d: got %0d want %0d", i, q0, exp_q[i]); end
            n_checks++; if (tc0 !== (exp_q[i] == 0)) begin n_fail++;
                $display("FAIL down_wrap_tc edge %0d: got %b want %b", i, tc0, exp_q[i] == 0); end
            n_checks++; if (w0 !== (i == 2)) begin n_fail++;
                $display("FAIL down_wrap_wrap edge %0d: got %b want %b", i, w0, i == 2); end
        end
    endtask

    task automatic test_sat();
        int exp_q[5];
        exp_q = '{4, 5, 5, 5, 5};
        mx = 8'd5; ud = 1'b1; pe_n = 1'b0; d = 8'd3;
        tick();
        pe_n = 1'b1; cep_n = 1'b0; cet_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (q1 !== 8'(exp_q[i])) begin n_fail++;
                $display("FAIL sat_q edge %0d: got %0d want %0d", i, q1, exp_q[i]); end
            n_checks++; if (w1 !== (i >= 2)) begin n_fail++;
                $display("FAIL sat_wrap edge %0d: got %b want %b", i, w1, i >= 2); end
        end
        pe_n = 1'b0; d = 8'd200;
        tick();
        n_checks++; if (q1 !== 8'd200 || w1 !== 1'b0) begin n_fail++;
            $display("FAIL sat_load_over: got q=%0d w=%b want q=200 w=0", q1, w1); end
        pe_n = 1'b1;
        tick();
        n_checks++; if (q1 !== 8'd5 || q0 !== 8'd0) begin n_fail++;
            $display("FAIL sat_clamp: got sat=%0d wrap=%0d want sat=5 wrap=0", q1, q0); end
    endtask

    task automatic test_priority();
        pe_n = 1'b0; d = 8'd7; cep_n = 1'b0; cet_n = 1'b0; ud = 1'b1; mx = 8'd7;
        tick();
        n_checks++; if (q0 !== 8'd7 || w0 !== 1'b0) begin n_fail++;
            $display("FAIL prio_load: got q=%0d w=%b want q=7 w=0", q0, w0); end
        pe_n = 1'b1; cep_n = 1'b1;
        tick();
        n_checks++; if (q0 !== 8'd7 || tc0 !== 1'b1 || w0 !== 1'b0) begin n_fail++;
            $display("FAIL prio_hold: got q=%0d tc=%b w=%b want q=7 tc=1 w=0", q0, tc0, w0); end
        cet_n = 1'b1; #1;
        n_checks++; if (tc0 !== 1'b0) begin n_fail++;
            $display("FAIL prio_cet_gate: got tc=%b want 0", tc0); end
        cet_n = 1'b0; mx = 8'd8; #1;
        n_checks++; if (tc0 !== 1'b0) begin n_fail++;
            $display("FAIL prio_max_change: got tc=%b want 0", tc0); end
    endtask

    task automatic test_max_zero();
        mx = 8'd0; pe_n = 1'b0; d = 8'd0;
        tick();
        pe_n = 1'b1; cep_n = 1'b0; cet_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ud = (i < 3);
            tick();
            n_checks++; if (q0 !== 8'd0 || q1 !== 8'd0) begin n_fail++;
                $display("FAIL max0_q edge %0d: got %0d/%0d want 0/0", i, q0, q1); end
            n_checks++; if (w0 !== 1'b1 || w1 !== 1'b1 || tc0 !== 1'b1) begin n_fail++;
                $display("FAIL max0_flags edge %0d: got w=%b/%b tc=%b want 1/1 1", i, w0, w1, tc0); end
        end
        cet_n = 1'b1; #1;
        n_checks++; if (tc0 !== 1'b0 || tc1 !== 1'b0) begin n_fail++;
            $display("FAIL max0_tc_off: got %b/%b want 0/0", tc0, tc1); end
    endtask

    task automatic test_mid_reset();
        mx = 8'd9; ud = 1'b1; pe_n = 1'b0; d = 8'd5; cep_n = 1'b0; cet_n = 1'b0;
        tick();
        pe_n = 1'b1;
        tick();
        cep_n = 1'b1;
        mr = 1'b1; #2; mr = 1'b0;
        tick();
        n_checks++; if (q0 !== 8'd6) begin n_fail++;
            $display("FAIL midreset_glitch: got %0d want 6", q0); end
        cep_n = 1'b0; mr = 1'b1;
        tick();
        n_checks++; if (q0 !== 8'd0 || w0 !== 1'b0) begin n_fail++;
            $display("FAIL midreset_q: got q=%0d w=%b want q=0 w=0", q0, w0); end
        mr = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            tick();
            n_checks++; if (q0 !== 8'(i)) begin n_fail++;
                $display("FAIL midreset_resume %0d: got %0d want %0d", i, q0, i); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            mr    = ($urandom_range(0, 24) == 0);
            pe_n  = ($urandom_range(0, 7) != 0);
            cep_n = ($urandom_range(0, 4) == 0);
            cet_n = ($urandom_range(0, 4) == 0);
            ud    = 1'($urandom_range(0, 1));
            mx    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
            d     = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 14));
            #1;
            n_checks++; if (tc0 !== ref_tc(mq0, int'(mx), ud, cet_n) || tc1 !== ref_tc(mq1, int'(mx), ud, cet_n)) begin
                n_fail++;
                $display("FAIL rand_tc %0d: got %b/%b want %b/%b", i, tc0, tc1,
                         ref_tc(mq0, int'(mx), ud, cet_n), ref_tc(mq1, int'(mx), ud, cet_n)); end
            tick();
            n_checks++; if (q0 !== 8'(mq0) || w0 !== mw0) begin n_fail++;
                $display("FAIL rand_wrapdut %0d: got q=%0d w=%b want q=%0d w=%b", i, q0, w0, mq0, mw0); end
            n_checks++; if (q1 !== 8'(mq1) || w1 !== mw1) begin n_fail++;
                $display("FAIL rand_satdut %0d: got q=%0d w=%b want q=%0d w=%b", i, q1, w1, mq1, mw1); end
        end
        mr = 1'b0;
    endtask

    task automatic test_cascade();
        int pulses = 0;
        c_mr = 1'b1; c_cep_n = 1'b1;
        tick();
        c_mr = 1'b0; c_cep_n = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (w_hi) pulses++;
        end
        c_cep_n = 1'b1;
        n_checks++; if ({q_hi, q_lo} !== 8'd44) begin n_fail++;
            $display("FAIL cascade_value: got %0d want 44", {q_hi, q_lo}); end
        n_checks++; if (pulses != 1) begin n_fail++;
            $display("FAIL cascade_hi_wrap: got %0d pulses want 1", pulses); end
    endtask

    initial begin
        mq0 = 0; mq1 = 0; mw0 = 1'b0; mw1 = 1'b0;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_sat();
        test_priority();
        test_max_zero();
        test_mid_reset();
        test_random();
        test_cascade();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
